// File: rtl/uart_sample_assembler.sv
// -----------------------------------------------------------------------------
// uart_sample_assembler
//
// Receives a UART byte stream (8N1, LSB first, idle high) and packs pairs of
// bytes into signed 16-bit samples for an N-point FFT frame. The first valid
// byte of a pair is the low byte, and the second is the high byte. Each
// assembled sample is sign-extended to bit_width bits and presented with a
// one-cycle strobe and its index within the current frame.
//
// Parameters
//   CLKS_PER_BIT : clk cycles per UART bit (434 = 50 MHz / 115200 baud)
//   N            : samples per frame (power of two, 4..4096)
//   bit_width    : width of sample_out (>= 16)
//
// Ports
//   clk          : system clock, rising edge
//   rst_n        : asynchronous active-low reset
//   data_in      : asynchronous UART serial line
//   sample_out   : signed sample, sign-extended from 16 bits, held between strobes
//   sample_valid : one-cycle strobe qualifying sample_out / sample_idx
//   sample_idx   : position of the sample within the frame, held between strobes
//   frame_done   : one-cycle strobe together with the last sample of a frame
//   frame_err    : one-cycle strobe when a stop bit is sampled low
// -----------------------------------------------------------------------------
module uart_sample_assembler #(
  parameter int CLKS_PER_BIT = 434,
  parameter int N            = 256,
  parameter int bit_width    = 26
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        data_in,
  output logic signed [bit_width-1:0] sample_out,
  output logic                        sample_valid,
  output logic [$clog2(N)-1:0]        sample_idx,
  output logic                        frame_done,
  output logic                        frame_err
);

  localparam int IDX_W  = $clog2(N);
  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  // Terminal counts: START waits half a bit to land on the middle of the
  // start bit; every later sample is one full bit after the previous one.
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t              state;
  logic                sync1;
  logic                sync2;
  logic                rx;
  logic [BAUD_W-1:0]   baud_cnt;
  logic [2:0]          bit_cnt;
  logic [7:0]          shift_reg;
  logic [7:0]          lo_byte;
  logic                hi_phase;
  logic                break_wait;
  logic [IDX_W-1:0]    frame_cnt;
  logic signed [15:0]  word;

  // Two-flop synchronizer. The flops reset to the idle (high) line level so
  // that reset release is never mistaken for a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= data_in;
      sync2 <= sync1;
    end
  end

  assign rx = sync2;

  // The high byte is still in the shift register when the stop bit is
  // accepted, so the full word is formed directly from it.
  assign word = {shift_reg, lo_byte};

  // RX state machine and sample assembler. Both live in one block so that the
  // sample strobe comes out in the cycle right after the stop-bit sample.
  // break_wait blocks re-arming after a framing error until the line has
  // been seen high again, so a held-low (break) line is not read as data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      baud_cnt     <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      lo_byte      <= '0;
      hi_phase     <= 1'b0;
      break_wait   <= 1'b0;
      frame_cnt    <= '0;
      sample_out   <= '0;
      sample_idx   <= '0;
      sample_valid <= 1'b0;
      frame_done   <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      frame_done   <= 1'b0;
      frame_err    <= 1'b0;

      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (break_wait) begin
            if (rx) begin
              break_wait <= 1'b0;
            end
          end else if (!rx) begin
            state <= START;
          end
        end

        START: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            // A line that is high again at mid start bit was only a glitch.
            state    <= rx ? IDLE : DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt  <= '0;
            shift_reg <= {rx, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        STOP: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            state    <= IDLE;
            if (!rx) begin
              // Bad stop bit: drop the byte and realign to a low byte.
              frame_err  <= 1'b1;
              break_wait <= 1'b1;
              hi_phase   <= 1'b0;
            end else if (!hi_phase) begin
              lo_byte  <= shift_reg;
              hi_phase <= 1'b1;
            end else begin
              hi_phase     <= 1'b0;
              sample_out   <= bit_width'(word);
              sample_idx   <= frame_cnt;
              sample_valid <= 1'b1;
              if (frame_cnt == IDX_LAST) begin
                frame_done <= 1'b1;
                frame_cnt  <= '0;
              end else begin
                frame_cnt <= frame_cnt + 1'b1;
              end
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_sample_assembler.md
UART_SAMPLE_ASSEMBLER -- requirements
Module: uart_sample_assembler

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clk cycles per UART bit (50 MHz / 115200 baud).
REQ-002 SHALL have parameter N, default 256, meaning samples per FFT frame (power of two, 4..4096).
REQ-003 SHALL have parameter bit_width, default 26, meaning output sample width (>= 16).
REQ-004 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port data_in, input, 1, asynchronous UART serial line (8N1, LSB first, idle high).
REQ-007 SHALL have port sample_out, output, bit_width, signed sample, sign-extended from 16 bits.
REQ-008 SHALL have port sample_valid, output, 1, one-cycle strobe qualifying sample_out and sample_idx.
REQ-009 SHALL have port sample_idx, output, log2(N), position of the sample within the frame.
REQ-010 SHALL have port frame_done, output, 1, one-cycle strobe on the last sample of a frame.
REQ-011 SHALL have port frame_err, output, 1, one-cycle strobe on a UART framing error.

Function
REQ-012 SHALL pass data_in through a 2-flop synchronizer whose flops reset to 1; all RX logic SHALL use the synchronized value.
REQ-013 SHALL implement RX FSM states IDLE, START, DATA and STOP, with a baud counter and a 3-bit bit counter.
REQ-014 IDLE -> START SHALL occur on a synchronized low; the baud counter SHALL clear.
REQ-015 START SHALL re-sample the line after CLKS_PER_BIT/2 cycles; if low, go to DATA; if high, treat as a glitch and return to IDLE with no output.
REQ-016 DATA SHALL sample each bit every CLKS_PER_BIT cycles at mid-bit, shifting LSB first; after 8 bits it SHALL go to STOP.
REQ-017 STOP SHALL sample at mid-bit; if high, the byte is valid; if low, frame_err SHALL pulse and the byte SHALL be discarded. Either way the FSM returns to IDLE on the next cycle.
REQ-018 IDLE SHALL not re-arm while the line is still low after a framing error, i.e. a break condition; it SHALL wait for a synchronized high first.
REQ-019 Assembler byte order: first valid byte is the low byte, second valid byte is the high byte (little-endian, two's complement).
REQ-020 On the high byte, sample_out SHALL equal sign_extend({hi,lo}) and sample_valid SHALL pulse in the cycle after the stop-bit sample.
REQ-021 sample_idx SHALL equal the frame counter value while sample_valid is high; the counter SHALL increment after each sample.
REQ-022 When the counter equals N-1 at sample_valid, frame_done SHALL pulse in the same cycle and the counter SHALL wrap to 0.
REQ-023 A framing error SHALL reset the byte phase to "expect low byte"; the frame counter SHALL be unaffected.
REQ-024 sample_out and sample_idx SHALL hold their values between strobes.
REQ-025 No backpressure is provided: the consumer SHALL accept every sample_valid strobe.

Reset
REQ-026 While rst_n = 0, regardless of clock: FSM = IDLE; counters, byte phase and shift register = 0; synchronizer flops = 1; sample_out = 0; sample_idx = 0; sample_valid = frame_done = frame_err = 0.
REQ-027 Reset asserted mid-byte or mid-frame SHALL discard partial data; after release, the next start bit SHALL be treated as the low byte of sample 0.

Verification (bench uses CLKS_PER_BIT = 8, N = 4, bit_width = 26)
REQ-028 Send bytes 0x34, 0x12 -> one sample_valid strobe with sample_out = 0x0001234 and sample_idx = 0; frame_done = 0.
REQ-029 Send bytes 0x00, 0x80 -> sample_out = 0x3FF8000 (-32768 sign-extended).
REQ-030 Send 4 samples (8 bytes) back-to-back -> sample_idx sequence 0,1,2,3; frame_done high only with idx 3; a fifth sample gets idx 0.
REQ-031 Send low byte 0x55, then a byte with stop bit = 0, then 0x78, 0x56 -> frame_err pulses once; next sample_out = 0x0005678 (byte phase re-aligned).
REQ-032 Drive a low glitch of 2 cycles on data_in in IDLE -> no sample_valid, no frame_err; the FSM is back in IDLE within CLKS_PER_BIT/2 + 3 cycles.
REQ-033 Assert rst_n = 0 during the DATA state of the high byte, release, then send 0x01, 0x00 -> sample_out = 0x0000001 with sample_idx = 0.
